rx_symbol_filter: RTL and testbench
===================================

RX_SYMBOL_FILTER -- requirements
Module: rx_symbol_filter

Interface
REQ-001 Parameter COMMA_SYMBOL, default 10'h1BC: alignment comma symbol.
REQ-002 Parameter SKIP_SYMBOL, default 10'h1A1: clock-compensation skip symbol.
REQ-003 Parameter LOCK_COUNT, default 4: commas required to declare lock.
REQ-004 Parameter COMMA_WINDOW, default 64: max cycles allowed between commas.
REQ-005 local_clock  in  1  single clock for all logic; rising edge.
REQ-006 local_reset  in  1  asynchronous, active-low reset.
REQ-007 data_in  in  10  symbol from the elastic buffer read side.
REQ-008 skip_added  in  1  buffer read pointer stalled this cycle; data_in is a repeat.
REQ-009 underflow  in  1  buffer underflow indication.
REQ-010 data_out  out  10  registered payload symbol.
REQ-011 data_valid  out  1  data_out holds a payload symbol this cycle.
REQ-012 comma_seen  out  1  one-cycle pulse per accepted comma.
REQ-013 locked  out  1  high while the FSM is in LOCKED.
REQ-014 lock_lost  out  1  one-cycle pulse on LOCKED -> UNLOCKED.
REQ-015 removed_count  out  16  saturating count of dropped skip/stall cycles while locked.

Function
REQ-016 All inputs SHALL be sampled at the rising edge of local_clock; every output SHALL be registered with exactly 1 cycle of latency.
REQ-017 A sampled cycle is "comma" if data_in == COMMA_SYMBOL and skip_added == 0, "skip" if data_in == SKIP_SYMBOL or skip_added == 1, and "payload" otherwise.
REQ-018 FSM states SHALL be UNLOCKED, ACQUIRING and LOCKED, with reset state UNLOCKED.
REQ-019 gap_count SHALL clear on a comma, otherwise increment, and saturate at COMMA_WINDOW+1.
REQ-020 UNLOCKED: a comma SHALL move to ACQUIRING with comma_count = 1; all other inputs keep UNLOCKED.
REQ-021 ACQUIRING: a comma SHALL increment comma_count; reaching LOCK_COUNT SHALL move to LOCKED.
REQ-022 ACQUIRING: underflow == 1 or gap_count == COMMA_WINDOW on a non-comma cycle SHALL return to UNLOCKED with comma_count = 0.
REQ-023 LOCKED: underflow == 1 or gap_count == COMMA_WINDOW on a non-comma cycle SHALL move to UNLOCKED and pulse lock_lost for 1 cycle.
REQ-024 When underflow and a comma occur in the same cycle, underflow SHALL take priority.
REQ-025 data_valid SHALL be 1 only when the state is LOCKED, the cycle is payload, and no LOCKED-exit condition occurs that cycle.
REQ-026 data_out SHALL load data_in whenever data_valid is set; otherwise it SHALL hold its previous value.
REQ-027 comma_seen SHALL pulse for every comma in any state.
REQ-028 removed_count SHALL increment by 1 for each skip cycle while LOCKED, and SHALL hold at 16'hFFFF.
REQ-029 A comma in LOCKED SHALL never produce data_valid and SHALL clear gap_count.
REQ-030 A comma on the cycle that brings comma_count to LOCK_COUNT SHALL assert locked on the next cycle; the first payload can be valid one cycle later.

Reset
REQ-031 Reset assertion SHALL immediately force UNLOCKED, clear comma_count, gap_count and removed_count, and set data_out = 0 and data_valid, comma_seen, locked, lock_lost = 0.
REQ-032 Reset asserted mid-stream SHALL discard all in-flight state; after release, lock SHALL be re-acquired from scratch.
REQ-033 No output SHALL depend on undefined input values during the first cycle after reset release.

Verification
REQ-034 Lock acquisition: 4 commas with 3 payloads between each, then payload 10'h055 -> locked rises 1 cycle after the 4th comma; data_out = 10'h055 with data_valid = 1.
REQ-035 Skip removal: while LOCKED, send comma, SKIP_SYMBOL, then the same SKIP with skip_added = 1 for 2 cycles -> data_valid = 0 for those 3 cycles; removed_count += 3.
REQ-036 Comma timeout: while LOCKED, send 64 payload cycles without a comma -> lock_lost pulses once, locked = 0; the 64th payload is not valid.
REQ-037 Underflow: while LOCKED, assert underflow together with COMMA_SYMBOL -> UNLOCKED, lock_lost pulses, comma_seen pulses.
REQ-038 Partial acquisition: 2 commas, then a 64-cycle gap -> return to UNLOCKED; 4 more commas are needed to lock.
REQ-039 Reset mid-stream: assert local_reset asynchronously between edges while LOCKED with removed_count = 5 -> all outputs are 0 immediately; after release, locked stays 0 until 4 commas.

Source files
------------

// File: rtl/rx_symbol_filter.sv
// rx_symbol_filter: comma-based lock acquisition and skip/stall removal on elastic-buffer output
module rx_symbol_filter #(
  parameter logic [9:0] COMMA_SYMBOL = 10'h1BC,
  parameter logic [9:0] SKIP_SYMBOL  = 10'h1A1,
  parameter int         LOCK_COUNT   = 4,
  parameter int         COMMA_WINDOW = 64
) (
  input  logic        local_clock,
  input  logic        local_reset,
  input  logic [9:0]  data_in,
  input  logic        skip_added,
  input  logic        underflow,
  output logic [9:0]  data_out,
  output logic        data_valid,
  output logic        comma_seen,
  output logic        locked,
  output logic        lock_lost,
  output logic [15:0] removed_count
);
  localparam int GW = $clog2(COMMA_WINDOW + 2);
  localparam int CW = $clog2(LOCK_COUNT + 1);
  typedef enum logic [1:0] {UNLOCKED, ACQUIRING, LOCKED} state_t;
  state_t state, state_next;
  logic [GW-1:0] gap_count, gap_inc, gap_next;
  logic [CW-1:0] comma_count, comma_next;
  logic is_comma, is_skip, is_payload, timeout, drop, valid_next, remove;
  always_ff @(posedge local_clock or negedge local_reset)
    if (!local_reset) begin
      state       <= UNLOCKED;
      comma_count <= '0;
      gap_count   <= '0;
    end else begin
      state       <= state_next;
      comma_count <= comma_next;
      gap_count   <= gap_next;
    end
  // timeout fires on the COMMA_WINDOW-th consecutive non-comma cycle
  always_comb begin
    is_comma   = data_in == COMMA_SYMBOL && !skip_added;
    is_skip    = data_in == SKIP_SYMBOL || skip_added;
    is_payload = !is_comma && !is_skip;
    gap_inc    = gap_count == GW'(COMMA_WINDOW + 1) ? gap_count : gap_count + 1'b1;
    gap_next   = is_comma ? '0 : gap_inc;
    timeout    = !is_comma && gap_inc == GW'(COMMA_WINDOW);
    drop       = underflow || timeout;
    state_next = state;
    comma_next = comma_count;
    case (state)
      UNLOCKED:
        if (is_comma && !underflow) begin
          comma_next = CW'(1);
          if (LOCK_COUNT <= 1) state_next = LOCKED;
          else state_next = ACQUIRING;
        end
      ACQUIRING:
        if (drop) begin
          state_next = UNLOCKED;
          comma_next = '0;
        end else if (is_comma) begin
          comma_next = comma_count + 1'b1;
          if (comma_next == CW'(LOCK_COUNT)) state_next = LOCKED;
        end
      LOCKED:
        if (drop) begin
          state_next = UNLOCKED;
          comma_next = '0;
        end
      default: state_next = UNLOCKED;
    endcase
  end
  always_comb begin
    valid_next = state == LOCKED && is_payload && !drop;
    remove     = state == LOCKED && is_skip && removed_count != 16'hFFFF;
  end
  always_ff @(posedge local_clock or negedge local_reset)
    if (!local_reset) begin
      data_out      <= '0;
      data_valid    <= 1'b0;
      comma_seen    <= 1'b0;
      locked        <= 1'b0;
      lock_lost     <= 1'b0;
      removed_count <= '0;
    end else begin
      data_valid    <= valid_next;
      comma_seen    <= is_comma;
      locked        <= state_next == LOCKED;
      lock_lost     <= state == LOCKED && drop;
      if (valid_next) data_out <= data_in;
      if (remove) removed_count <= removed_count + 1'b1;
    end
endmodule

// File: tb/tb_rx_symbol_filter.sv
// tb_rx_symbol_filter: directed checks of lock, skip removal, timeout, underflow and reset
module tb_rx_symbol_filter;
  localparam logic [9:0] C = 10'h1BC;
  localparam logic [9:0] S = 10'h1A1;
  logic        local_clock = 0;
  logic        local_reset = 0;
  logic [9:0]  data_in = '0;
  logic        skip_added = 0;
  logic        underflow = 0;
  logic [9:0]  data_out;
  logic        data_valid, comma_seen, locked, lock_lost;
  logic [15:0] removed_count;
  int tests = 0;
  int fails = 0;
  rx_symbol_filter dut (
    .local_clock(local_clock), .local_reset(local_reset), .data_in(data_in),
    .skip_added(skip_added), .underflow(underflow), .data_out(data_out),
    .data_valid(data_valid), .comma_seen(comma_seen), .locked(locked),
    .lock_lost(lock_lost), .removed_count(removed_count)
  );
  always #5 local_clock = ~local_clock;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic step(input logic [9:0] d, input logic s, input logic u);
    @(negedge local_clock);
    data_in = d;
    skip_added = s;
    underflow = u;
    @(posedge local_clock);
    #1;
  endtask
  initial begin
    #12;
    check("rst_locked", locked, 0);
    check("rst_valid", data_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_removed", removed_count, 0);
    check("rst_comma", comma_seen, 0);
    @(negedge local_clock);
    local_reset = 1;
    // acquisition: 4 commas, 3 payloads between each
    for (int k = 0; k < 4; k++) begin
      step(C, 0, 0);
      check("acq_comma_seen", comma_seen, 1);
      check("acq_locked", locked, k == 3);
      if (k < 3) begin
        repeat (3) step(10'h0AA, 0, 0);
        check("acq_no_valid", data_valid, 0);
      end
    end
    step(10'h055, 0, 0);
    check("first_valid", data_valid, 1);
    check("first_data", data_out, 10'h055);
    // skip removal
    step(C, 0, 0);
    check("lk_comma_valid", data_valid, 0);
    check("lk_comma_hold", data_out, 10'h055);
    step(S, 0, 0);
    check("skip_valid", data_valid, 0);
    check("skip_comma_seen", comma_seen, 0);
    repeat (2) begin
      step(S, 1, 0);
      check("stall_valid", data_valid, 0);
    end
    check("removed_3", removed_count, 3);
    repeat (2) step(10'h123, 1, 0);
    check("removed_5", removed_count, 5);
    step(10'h077, 0, 0);
    check("post_skip_valid", data_valid, 1);
    check("post_skip_data", data_out, 10'h077);
    // comma timeout
    step(C, 0, 0);
    for (int i = 1; i <= 64; i++) begin
      step(10'(i), 0, 0);
      if (i == 63) begin
        check("to63_valid", data_valid, 1);
        check("to63_locked", locked, 1);
        check("to63_lost", lock_lost, 0);
      end
    end
    check("to64_valid", data_valid, 0);
    check("to64_lost", lock_lost, 1);
    check("to64_locked", locked, 0);
    check("to64_hold", data_out, 10'd63);
    step(10'h0AA, 0, 0);
    check("lost_pulse_end", lock_lost, 0);
    // underflow together with comma
    repeat (4) step(C, 0, 0);
    check("relock", locked, 1);
    step(10'h055, 0, 0);
    check("relock_valid", data_valid, 1);
    step(C, 0, 1);
    check("uf_locked", locked, 0);
    check("uf_lost", lock_lost, 1);
    check("uf_comma_seen", comma_seen, 1);
    check("uf_valid", data_valid, 0);
    // 63-cycle gap keeps acquisition progress
    repeat (2) step(C, 0, 0);
    repeat (63) step(10'h0AA, 0, 0);
    step(C, 0, 0);
    check("gap63_3rd", locked, 0);
    step(C, 0, 0);
    check("gap63_4th", locked, 1);
    step(10'h055, 0, 1);
    check("uf_payload_locked", locked, 0);
    check("uf_payload_lost", lock_lost, 1);
    // 64-cycle gap discards partial acquisition
    repeat (2) step(C, 0, 0);
    repeat (64) step(10'h0AA, 0, 0);
    repeat (3) step(C, 0, 0);
    check("gap64_3rd", locked, 0);
    step(C, 0, 0);
    check("gap64_4th", locked, 1);
    check("removed_kept", removed_count, 5);
    // asynchronous reset mid-stream
    step(10'h0AA, 0, 0);
    check("pre_rst_valid", data_valid, 1);
    #2 local_reset = 0;
    #1;
    check("arst_locked", locked, 0);
    check("arst_valid", data_valid, 0);
    check("arst_data", data_out, 0);
    check("arst_removed", removed_count, 0);
    @(negedge local_clock);
    local_reset = 1;
    repeat (3) step(C, 0, 0);
    check("post_rst_3rd", locked, 0);
    step(C, 0, 0);
    check("post_rst_4th", locked, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
